// File: rtl/axis_byte_bridge.sv
// Byte-stream <-> word-stream bridge: packs received bytes into INP_WIDTH words and
// unpacks OUT_WIDTH words into bytes, LSB first, with idle-timeout and flush recovery.
module axis_byte_bridge #(
    parameter int INP_WIDTH      = 24,
    parameter int OUT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DROP_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  arstn,

    input  logic [7:0]            s_byte_tdata,
    input  logic                  s_byte_tvalid,
    output logic                  s_byte_tready,

    output logic [INP_WIDTH-1:0]  m_inp_tdata,
    output logic                  m_inp_tvalid,
    input  logic                  m_inp_tready,

    input  logic [OUT_WIDTH-1:0]  s_out_tdata,
    input  logic                  s_out_tvalid,
    output logic                  s_out_tready,

    output logic [7:0]            m_byte_tdata,
    output logic                  m_byte_tvalid,
    input  logic                  m_byte_tready,

    input  logic                  flush,
    output logic                  rx_partial,
    output logic                  timeout_pulse,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int INP_BYTES = (INP_WIDTH + 7) / 8;
    localparam int OUT_BYTES = (OUT_WIDTH + 7) / 8;
    localparam int INP_BITS  = INP_BYTES * 8;
    localparam int OUT_BITS  = OUT_BYTES * 8;
    localparam int RX_IDX_W  = (INP_BYTES > 1) ? $clog2(INP_BYTES) : 1;
    localparam int TX_IDX_W  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int TMR_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMR_EN    = (TIMEOUT_CYCLES > 0);

    localparam logic [RX_IDX_W-1:0] RX_LAST  = RX_IDX_W'(INP_BYTES - 1);
    localparam logic [TX_IDX_W-1:0] TX_LAST  = TX_IDX_W'(OUT_BYTES - 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (v == {DROP_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [INP_BITS-1:0] rx_asm;
    logic [INP_BITS-1:0] rx_asm_next;
    logic [RX_IDX_W-1:0] rx_idx;
    logic [TMR_W-1:0]    rx_tmr;
    logic                byte_acc;
    logic                byte_last;
    logic                tmr_expire;
    logic                flush_drop;
    logic                drop_evt;

    logic [OUT_BITS-1:0] tx_sh;
    logic [TX_IDX_W-1:0] tx_idx;
    logic                tx_busy;
    logic                word_acc;
    logic                byte_out;

    // RX: byte acceptance and discard decisions
    assign s_byte_tready = !flush && ((rx_idx != RX_LAST) || !m_inp_tvalid || m_inp_tready);
    assign byte_acc      = s_byte_tvalid && s_byte_tready;
    assign byte_last     = (rx_idx == RX_LAST);
    assign rx_partial    = (rx_idx != '0);
    // An accepted byte on the expiry cycle keeps the partial word alive.
    assign tmr_expire    = TMR_EN && (rx_idx != '0) && !byte_acc && (rx_tmr == TMR_LAST);
    assign flush_drop    = flush && (rx_idx != '0);
    assign drop_evt      = tmr_expire || flush_drop;

    always_comb begin
        rx_asm_next = rx_asm;
        for (int k = 0; k < INP_BYTES; k++) begin
            if (rx_idx == RX_IDX_W'(k)) begin
                rx_asm_next[8*k +: 8] = s_byte_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_asm       <= '0;
            rx_idx       <= '0;
            m_inp_tdata  <= '0;
            m_inp_tvalid <= 1'b0;
        end else begin
            if (m_inp_tready) begin
                m_inp_tvalid <= 1'b0;
            end
            if (byte_acc) begin
                rx_asm <= rx_asm_next;
                if (byte_last) begin
                    m_inp_tdata  <= rx_asm_next[INP_WIDTH-1:0];
                    m_inp_tvalid <= 1'b1;
                    rx_idx       <= '0;
                end else begin
                    rx_idx <= rx_idx + 1'b1;
                end
            end else if (drop_evt) begin
                rx_idx <= '0;
            end
        end
    end

    // RX: idle timer, timeout pulse and drop counter
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_tmr        <= '0;
            timeout_pulse <= 1'b0;
            drop_count    <= '0;
        end else begin
            timeout_pulse <= tmr_expire;
            if (byte_acc || (rx_idx == '0) || drop_evt) begin
                rx_tmr <= '0;
            end else begin
                rx_tmr <= rx_tmr + 1'b1;
            end
            if (drop_evt) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    // TX: word latch and byte shifter
    assign s_out_tready  = !tx_busy;
    assign m_byte_tvalid = tx_busy;
    assign m_byte_tdata  = tx_sh[7:0];
    assign word_acc      = s_out_tvalid && s_out_tready;
    assign byte_out      = m_byte_tvalid && m_byte_tready;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_sh   <= '0;
            tx_idx  <= '0;
            tx_busy <= 1'b0;
        end else if (word_acc) begin
            tx_sh   <= OUT_BITS'(s_out_tdata);
            tx_idx  <= '0;
            tx_busy <= 1'b1;
        end else if (byte_out) begin
            if (tx_idx == TX_LAST) begin
                tx_busy <= 1'b0;
            end else begin
                tx_sh  <= tx_sh >> 8;
                tx_idx <= tx_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_byte_bridge.sv
// Bench for axis_byte_bridge: a reference model pushes expected words/bytes into queues,
// monitors pop and compare on every output handshake; status outputs are compared per cycle.
module tb_axis_byte_bridge;

    localparam int IW = 20;
    localparam int OW = 12;
    localparam int TC = 10;
    localparam int DW = 2;
    localparam int IB = (IW + 7) / 8;
    localparam int OB = (OW + 7) / 8;

    logic          clk;
    logic          arstn;
    logic [7:0]    s_byte_tdata;
    logic          s_byte_tvalid;
    logic          s_byte_tready;
    logic [IW-1:0] m_inp_tdata;
    logic          m_inp_tvalid;
    logic          m_inp_tready = 1'b1;
    logic [OW-1:0] s_out_tdata;
    logic          s_out_tvalid;
    logic          s_out_tready;
    logic [7:0]    m_byte_tdata;
    logic          m_byte_tvalid;
    logic          m_byte_tready = 1'b1;
    logic          flush;
    logic          rx_partial;
    logic          timeout_pulse;
    logic [DW-1:0] drop_count;

    axis_byte_bridge #(
        .INP_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TC), .DROP_WIDTH(DW)
    ) dut (
        .clk(clk), .arstn(arstn),
        .s_byte_tdata(s_byte_tdata), .s_byte_tvalid(s_byte_tvalid), .s_byte_tready(s_byte_tready),
        .m_inp_tdata(m_inp_tdata), .m_inp_tvalid(m_inp_tvalid), .m_inp_tready(m_inp_tready),
        .s_out_tdata(s_out_tdata), .s_out_tvalid(s_out_tvalid), .s_out_tready(s_out_tready),
        .m_byte_tdata(m_byte_tdata), .m_byte_tvalid(m_byte_tvalid), .m_byte_tready(m_byte_tready),
        .flush(flush), .rx_partial(rx_partial), .timeout_pulse(timeout_pulse), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]    part[$];
    logic [IW-1:0] exp_inp[$];
    logic [7:0]    exp_byte[$];
    int            idle;
    bit            hold_vld;
    bit            pulse_exp;
    int            drops;
    int            tx_pend;

    // Ready generators
    bit inp_rnd = 0, inp_fix = 1, byte_rnd = 0, byte_fix = 1;
    always @(posedge clk) begin
        #1;
        m_inp_tready  = inp_rnd  ? (($urandom % 4) != 0) : inp_fix;
        m_byte_tready = byte_rnd ? (($urandom % 3) != 0) : byte_fix;
    end

    // Reference model: evaluated mid-cycle, predicts what the next rising edge does
    always @(negedge clk) begin
        bit rdy, acc, expire, fdrop, ordy;
        logic [31:0] w;
        if (!arstn) begin
            part.delete(); exp_inp.delete(); exp_byte.delete();
            idle = 0; hold_vld = 0; pulse_exp = 0; drops = 0; tx_pend = 0;
            chk("rst_inp_tvalid", 32'(m_inp_tvalid), 0);
            chk("rst_inp_tdata", 32'(m_inp_tdata), 0);
            chk("rst_byte_tvalid", 32'(m_byte_tvalid), 0);
            chk("rst_byte_tdata", 32'(m_byte_tdata), 0);
            chk("rst_out_tready", 32'(s_out_tready), 1);
            chk("rst_byte_tready", 32'(s_byte_tready), 1);
            chk("rst_rx_partial", 32'(rx_partial), 0);
            chk("rst_timeout_pulse", 32'(timeout_pulse), 0);
            chk("rst_drop_count", 32'(drop_count), 0);
        end else begin
            rdy = !flush && ((part.size() < IB - 1) || !hold_vld || m_inp_tready);
            acc = s_byte_tvalid && rdy;
            chk("s_byte_tready", 32'(s_byte_tready), 32'(rdy));
            chk("m_inp_tvalid", 32'(m_inp_tvalid), 32'(hold_vld));
            chk("rx_partial", 32'(rx_partial), 32'(part.size() != 0));
            chk("timeout_pulse", 32'(timeout_pulse), 32'(pulse_exp));
            chk("drop_count", 32'(drop_count), 32'(drops));

            expire = (TC > 0) && (part.size() != 0) && !acc && (idle == TC - 1);
            fdrop  = flush && (part.size() != 0);
            if (hold_vld && m_inp_tready) hold_vld = 0;
            if (acc) begin
                part.push_back(s_byte_tdata);
                if (part.size() == IB) begin
                    w = 0;
                    foreach (part[k]) w = w | (32'(part[k]) << (8 * k));
                    exp_inp.push_back(IW'(w));
                    part.delete();
                    hold_vld = 1;
                end
            end
            if (expire || fdrop) begin
                part.delete();
                if (drops < (1 << DW) - 1) drops++;
            end
            idle = (acc || part.size() == 0) ? 0 : idle + 1;
            pulse_exp = expire;

            ordy = (tx_pend == 0);
            chk("s_out_tready", 32'(s_out_tready), 32'(ordy));
            chk("m_byte_tvalid", 32'(m_byte_tvalid), 32'(tx_pend != 0));
            if (tx_pend != 0 && m_byte_tready) tx_pend--;
            if (s_out_tvalid && ordy) begin
                for (int k = 0; k < OB; k++) exp_byte.push_back(8'(32'(s_out_tdata) >> (8 * k)));
                tx_pend = OB;
            end
        end
    end

    // Output monitors: compare presented data with the queue head, pop on transfer
    always @(negedge clk) begin
        if (arstn) begin
            if (m_inp_tvalid) begin
                if (exp_inp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL inp_word: got 0x%0h, expected no word", m_inp_tdata);
                end else begin
                    chk("inp_word", 32'(m_inp_tdata), 32'(exp_inp[0]));
                    if (m_inp_tready) void'(exp_inp.pop_front());
                end
            end
            if (m_byte_tvalid) begin
                if (exp_byte.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_byte: got 0x%0h, expected no byte", m_byte_tdata);
                end else begin
                    chk("tx_byte", 32'(m_byte_tdata), 32'(exp_byte[0]));
                    if (m_byte_tready) void'(exp_byte.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit done = 0;
        s_byte_tdata  = b;
        s_byte_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = s_byte_tready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++; errors++;
                $display("FAIL byte_accept_timeout: byte 0x%0h not accepted within 200 cycles", b);
                done = 1;
            end
        end
        s_byte_tvalid = 1'b0;
    endtask

    task automatic send_word(input logic [OW-1:0] wd);
        int n = 0;
        bit done = 0;
        s_out_tdata  = wd;
        s_out_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = s_out_tready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++; errors++;
                $display("FAIL word_accept_timeout: word 0x%0h not accepted within 200 cycles", wd);
                done = 1;
            end
        end
        s_out_tvalid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b1;
        s_byte_tdata = '0; s_byte_tvalid = 1'b0;
        s_out_tdata = '0; s_out_tvalid = 1'b0;
        flush = 1'b0;
        #2 arstn = 1'b0;
        cyc(3);
        arstn = 1'b1;
        cyc(2);

        // Back-to-back pack
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        cyc(3);

        // Output backpressure stalls only the final byte
        inp_fix = 0;
        send_byte(8'hAB); send_byte(8'hFC); send_byte(8'h01);
        fork
            begin send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); end
            begin cyc(8); inp_fix = 1; end
        join
        cyc(3);

        // Idle timeout, then a flush with nothing assembled
        send_byte(8'h11); send_byte(8'h22);
        cyc(TC + 5);
        do_flush();
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        cyc(3);

        // Flush drops until the counter saturates
        repeat (5) begin
            send_byte(8'($urandom));
            do_flush();
        end
        cyc(2);

        // TX unpack with a stall
        fork
            send_word(12'hBEF);
            begin cyc(1); byte_fix = 0; cyc(2); byte_fix = 1; end
        join
        cyc(4);
        repeat (3) send_word(OW'($urandom));
        cyc(6);

        // Randomised traffic on both paths
        inp_rnd = 1; byte_rnd = 1;
        fork
            repeat (150) begin
                int r;
                r = int'($urandom % 16);
                if (r == 0) do_flush();
                else begin
                    send_byte(8'($urandom));
                    if (r >= 14) cyc(TC - 1 + int'($urandom % 3));
                    else if (r >= 11) cyc(int'($urandom % 3));
                end
            end
            repeat (80) begin
                send_word(OW'($urandom));
                cyc(int'($urandom % 3));
            end
        join
        inp_rnd = 0; byte_rnd = 0; inp_fix = 1; byte_fix = 1;
        cyc(20);

        // Reset in the middle of an RX word and a TX word
        send_byte(8'h77);
        send_word(12'hA5C);
        cyc(1);
        arstn = 1'b0;
        cyc(2);
        arstn = 1'b1;
        cyc(1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        cyc(20);

        chk("inp_queue_drained", 32'(exp_inp.size()), 0);
        chk("byte_queue_drained", 32'(exp_byte.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_byte_bridge.md
# axis_byte_bridge

Parametrised byte-stream/word-stream bridge between the UART byte AXI-Stream pair and a processor's input/output word streams of arbitrary width (not restricted to byte multiples). It packs received bytes into INP_WIDTH words and unpacks OUT_WIDTH words into bytes, least-significant byte first. Beyond plain width adaptation, it resynchronises on line idle: a timeout discards partially assembled input words, and a flush input and a drop counter support host recovery. It replaces the fixed rx/tx adapter pair in UART-attached processor tops.

## Interface

- INP_WIDTH, 24, processor input word width in bits, ≥1; INP_BYTES = ceil(INP_WIDTH/8)
- OUT_WIDTH, 16, processor output word width in bits, ≥1; OUT_BYTES = ceil(OUT_WIDTH/8)
- TIMEOUT_CYCLES, 1000, idle cycles before a partial input word is discarded; 0 disables the timeout
- DROP_WIDTH, 8, width of the saturating drop counter

- clk  input  1  sole clock, rising edge
- arstn  input  1  asynchronous active-low reset
- s_byte_tdata/tvalid/tready  in/in/out  8/1/1  received byte stream
- m_inp_tdata/tvalid/tready  out/out/in  INP_WIDTH/1/1  word to processor
- s_out_tdata/tvalid/tready  in/in/out  OUT_WIDTH/1/1  word from processor
- m_byte_tdata/tvalid/tready  out/out/in  8/1/1  byte stream to transmitter
- flush  input  1  synchronous; discards the partial input word
- rx_partial  output  1  high while 1..INP_BYTES-1 bytes are assembled
- timeout_pulse  output  1  one-cycle pulse when a partial word is discarded by timeout
- drop_count  output  DROP_WIDTH  saturating count of partial words discarded (timeout or flush)

## Operation

- Reset: all tvalid outputs 0; s_out_tready 1; s_byte_tready 1; rx_partial 0; timeout_pulse 0; drop_count 0; data registers 0; both byte indices 0.
- A transfer occurs on a cycle where tvalid && tready are high at a rising edge.
- RX packing: an assembly register plus a byte index 0..INP_BYTES-1. Byte k fills bits [8k+7:8k]. Bits at or above INP_WIDTH in the final byte are discarded.
- When the final byte is accepted, the assembled word moves to the output register: m_inp_tvalid is set and the index returns to 0.
- s_byte_tready = !flush && (index < INP_BYTES-1 || !m_inp_tvalid || m_inp_tready). Non-final bytes are never stalled by a held output word.
- m_inp_tdata is stable while m_inp_tvalid && !m_inp_tready.
- Idle timer: counts cycles while index ≠ 0 and no byte is accepted; it clears on any accepted byte and on index = 0.
  - When the timer reaches TIMEOUT_CYCLES, the partial word is discarded, index goes to 0, timeout_pulse is high for one cycle, and drop_count increments.
  - A byte accepted on the expiry cycle cancels the expiry.
- flush: if index ≠ 0, the partial word is discarded and drop_count increments; s_byte_tready is 0 during flush. The held m_inp word and the TX path are unaffected.
- drop_count saturates at 2^DROP_WIDTH-1. A timeout coinciding with a flush counts as one drop.
- TX unpacking: s_out_tready = 1 only when no word is held.
  - An accepted word is latched. Byte k = bits [8k+7:8k], with bits above OUT_WIDTH zero-filled.
  - m_byte_tvalid stays high until OUT_BYTES bytes have transferred, then s_out_tready returns to 1.
  - m_byte_tdata is stable while stalled.
- The RX and TX paths are fully independent.
- INP_BYTES = 1 or OUT_BYTES = 1 degenerates to a registered pass-through of one byte per word.

## Timing

- RX: final byte accepted at edge N → m_inp_tvalid high after N. Full rate is one byte per cycle; word throughput is 1 per INP_BYTES cycles.
- TX: word accepted at edge N → first byte valid after N. The next s_out_tready rises after the edge transferring the last byte. Word throughput is 1 per OUT_BYTES+1 cycles.
- Timeout: last byte at edge N, no further bytes → discard at edge N+TIMEOUT_CYCLES; timeout_pulse high for the following cycle.
- arstn is asserted asynchronously at any time and returns all state to reset values immediately. Partial words and held words are lost and not counted as drops.

## Test plan

- RX pack, INP_WIDTH=24: bytes 0x11,0x22,0x33 back-to-back, m_inp_tready=1 → m_inp_tdata=0x332211, tvalid for exactly 1 cycle, one cycle after the third byte.
- RX backpressure plus odd width, INP_WIDTH=12: bytes 0xAB,0xFC, then 0x01,0x02 with m_inp_tready=0 → first word 0xCAB held stable. Byte 0x01 is accepted; s_byte_tready stays 0 on 0x02 until m_inp_tready=1, after which the second word is 0x201.
- Timeout, TIMEOUT_CYCLES=10: bytes 0x11,0x22 then idle → after 10 idle cycles timeout_pulse=1, rx_partial=0, drop_count=1. Bytes 0x44,0x55,0x66 then yield 0x665544.
- Flush plus saturation, DROP_WIDTH=2: five cycles of "1 byte then flush" → drop_count 1,2,3,3,3. Flush with index 0 does not increment.
- TX unpack, OUT_WIDTH=16: word 0xBEEF, m_byte_tready toggling 1,0,1 → bytes 0xEF then 0xBE; data stable during the stall; s_out_tready low until 0xBE transfers.
- Reset mid-operation: arstn low after 1 RX byte and 1 TX byte → all outputs at reset values. The next RX word assembles from index 0 and drop_count=0.
